sb_trans_scheduler: RTL and testbench
=====================================

SB_TRANS_SCHEDULER -- requirements
Module: sb_trans_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles before an issued transaction is abandoned (legal range 2..1023).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles enforced between transactions (legal range 1..15).
REQ-003 SHALL have port sb_clk, input, 1 bit: sideband clock; the only clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port lt_req, input, 1 bit: level request for an LT (LSE/CLSE) transaction, held until lt_ack.
REQ-006 SHALL have port at_cmd_req, input, 1 bit: level request for an AT read command, held until at_cmd_ack.
REQ-007 SHALL have port at_rsp_req, input, 1 bit: level request for an AT read response, held until at_rsp_ack.
REQ-008 SHALL have port disconnected_s, input, 1 bit: transactions generator is in its disconnected state.
REQ-009 SHALL have port trans_sent, input, 1 bit: one-cycle pulse from the generator marking transaction completion.
REQ-010 SHALL have port trans_sel, output, 3 bits: transaction select to the generator (0 none, 2 AT command, 3 AT response, 4 LT).
REQ-011 SHALL have ports lt_ack, at_cmd_ack, at_rsp_ack, outputs, 1 bit each: one-cycle completion pulses.
REQ-012 SHALL have port busy, output, 1 bit: high in WAIT and GAP states.
REQ-013 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a transaction is abandoned.

Function
REQ-014 SHALL implement four states: DISC, IDLE, WAIT, GAP; all outputs registered.
REQ-015 DISC: SHALL move to IDLE at the first edge sampling disconnected_s=0.
REQ-016 IDLE: with any request, SHALL select a winner, drive its trans_sel code for exactly one cycle (the cycle after the sampling edge), clear the WAIT counter, and enter WAIT.
REQ-017 Arbitration SHALL be: lt_req highest priority; between at_cmd_req and at_rsp_req, round-robin with a 1-bit pointer favouring the requester not granted most recently.
REQ-018 The round-robin pointer SHALL update only on successful completion (trans_sent), never on timeout or disconnect.
REQ-019 trans_sel SHALL be 0 in every cycle other than the single issue cycle.
REQ-020 WAIT: trans_sent=1 SHALL pulse the granted requester's ack in the next cycle, load the gap counter, and enter GAP.
REQ-021 WAIT: the counter SHALL increment each WAIT cycle; if it equals TIMEOUT_CYCLES-1 with trans_sent=0, SHALL pulse timeout_err in the next cycle, issue no ack, and enter GAP.
REQ-022 trans_sent and timeout in the same cycle: trans_sent SHALL win (ack, no timeout_err).
REQ-023 GAP: SHALL stay exactly GAP_CYCLES cycles, then enter IDLE; requests are not sampled in GAP.
REQ-024 disconnected_s=1 in any state SHALL force DISC on the next edge, with no ack, no timeout_err, trans_sel=0, and the grant discarded; it takes priority over trans_sent.
REQ-025 trans_sent outside WAIT SHALL be ignored.
REQ-026 Request deassertion during WAIT SHALL NOT cancel the transaction; the ack still fires on completion.
REQ-027 Counters SHALL saturate, never wrap; widths sized to the parameter maxima (10-bit WAIT, 4-bit gap).

Reset
REQ-028 rst=1 sampled at an edge SHALL set state DISC, trans_sel=0, all acks 0, busy=0, timeout_err=0, counters 0, and the pointer favouring at_rsp_req.
REQ-029 rst SHALL override every other input in the same cycle, including mid-WAIT; no ack or timeout_err shall follow.

Verification
REQ-030 Reset, then disconnected_s 1->0 and lt_req=1 -> DISC, then IDLE, then trans_sel=4 for one cycle; trans_sent 30 cycles later -> lt_ack pulse, busy low 2 cycles after GAP entry.
REQ-031 lt_req, at_cmd_req, at_rsp_req all high from reset -> grant order 4, 3, 2, then 4 repeats while lt_req held.
REQ-032 at_cmd_req only, trans_sent never -> timeout_err pulse exactly 255 cycles after issue, no at_cmd_ack, re-issue of trans_sel=2 after GAP.
REQ-033 trans_sent coinciding with the final WAIT cycle -> ack pulse, timeout_err stays 0.
REQ-034 disconnected_s=1 mid-WAIT together with trans_sent -> DISC next edge, no ack; reconnect -> request re-issued.
REQ-035 rst=1 asserted mid-WAIT for one cycle -> all outputs 0 next cycle, no ack/timeout_err; trans_sent pulse while in IDLE -> ignored.

Source files
------------

// File: rtl/sb_trans_scheduler.sv
// sb_trans_scheduler: arbitrates LT/AT sideband requests, issues one transaction at a time with timeout and inter-transaction gap
module sb_trans_scheduler #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       lt_req,
  input  logic       at_cmd_req,
  input  logic       at_rsp_req,
  input  logic       disconnected_s,
  input  logic       trans_sent,
  output logic [2:0] trans_sel,
  output logic       lt_ack,
  output logic       at_cmd_ack,
  output logic       at_rsp_ack,
  output logic       busy,
  output logic       timeout_err
);
  typedef enum logic [1:0] {DISC, IDLE, WAIT, GAP} state_t;
  localparam logic [9:0] W_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] G_LAST = 4'(GAP_CYCLES - 1);
  state_t     r_state;
  logic [9:0] r_wcnt;
  logic [3:0] r_gcnt;
  logic [2:0] r_grant;
  logic       r_ptr;
  logic       w_any;
  logic [2:0] w_pick;
  // r_ptr=1 favours at_rsp_req when both AT requests are pending
  always_comb begin
    w_any  = lt_req | at_cmd_req | at_rsp_req;
    w_pick = lt_req ? 3'd4 :
             (at_cmd_req && at_rsp_req) ? (r_ptr ? 3'd3 : 3'd2) :
             at_rsp_req ? 3'd3 :
             at_cmd_req ? 3'd2 : 3'd0;
  end
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      r_state     <= DISC;
      r_wcnt      <= '0;
      r_gcnt      <= '0;
      r_grant     <= '0;
      r_ptr       <= 1'b1;
      trans_sel   <= '0;
      lt_ack      <= 1'b0;
      at_cmd_ack  <= 1'b0;
      at_rsp_ack  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      trans_sel   <= '0;
      lt_ack      <= 1'b0;
      at_cmd_ack  <= 1'b0;
      at_rsp_ack  <= 1'b0;
      timeout_err <= 1'b0;
      if (disconnected_s) begin
        r_state <= DISC;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          DISC: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
          IDLE: if (w_any) begin
            trans_sel <= w_pick;
            r_grant   <= w_pick;
            r_wcnt    <= '0;
            r_state   <= WAIT;
            busy      <= 1'b1;
          end
          WAIT: if (trans_sent) begin
            lt_ack     <= r_grant == 3'd4;
            at_cmd_ack <= r_grant == 3'd2;
            at_rsp_ack <= r_grant == 3'd3;
            if (r_grant != 3'd4) r_ptr <= r_grant == 3'd2;
            r_gcnt     <= '0;
            r_state    <= GAP;
          end else if (r_wcnt == W_LAST) begin
            timeout_err <= 1'b1;
            r_gcnt      <= '0;
            r_state     <= GAP;
          end else if (r_wcnt != '1) begin
            r_wcnt <= r_wcnt + 10'd1;
          end
          GAP: if (r_gcnt == G_LAST) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else if (r_gcnt != '1) begin
            r_gcnt <= r_gcnt + 4'd1;
          end
          default: r_state <= DISC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sb_trans_scheduler.sv
// tb_sb_trans_scheduler: directed vector table plus multi-cycle sequences for timeout, arbitration and gap timing
module tb_sb_trans_scheduler;
  logic       sb_clk = 1'b0;
  logic       rst, lt_req, at_cmd_req, at_rsp_req, disconnected_s, trans_sent;
  logic [2:0] trans_sel;
  logic       lt_ack, at_cmd_ack, at_rsp_ack, busy, timeout_err;
  logic [7:0] w_out;
  int         n_chk = 0;
  int         n_fail = 0;
  typedef struct packed {
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[23];
  always #5 sb_clk = ~sb_clk;
  sb_trans_scheduler #(.TIMEOUT_CYCLES(255), .GAP_CYCLES(2)) dut (
    .sb_clk(sb_clk), .rst(rst), .lt_req(lt_req), .at_cmd_req(at_cmd_req),
    .at_rsp_req(at_rsp_req), .disconnected_s(disconnected_s), .trans_sent(trans_sent),
    .trans_sel(trans_sel), .lt_ack(lt_ack), .at_cmd_ack(at_cmd_ack),
    .at_rsp_ack(at_rsp_ack), .busy(busy), .timeout_err(timeout_err)
  );
  assign w_out = {trans_sel, lt_ack, at_cmd_ack, at_rsp_ack, busy, timeout_err};
  function automatic vec_t mk(input logic [5:0] i, input logic [7:0] o);
    return vec_t'({i, o});
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge sb_clk);
  endtask
  task automatic wait_sel(input int budget, output logic [2:0] code, output int cyc);
    cyc = 0;
    while (trans_sel == 3'd0 && cyc < budget) begin
      tick();
      cyc++;
    end
    code = trans_sel;
  endtask
  task automatic do_reset();
    {rst, disconnected_s, lt_req, at_cmd_req, at_rsp_req, trans_sent} = 6'b110000;
    tick();
    rst = 1'b0;
    disconnected_s = 1'b0;
    tick();
  endtask
  initial begin
    logic [2:0] c;
    logic [2:0] order[3];
    int cy, t;
    logic saw;
    // in: rst dis lt cmd rsp sent | exp: sel lt_ack cmd_ack rsp_ack busy terr
    tbl[0]  = mk(6'b100000, 8'b000_000_00);
    tbl[1]  = mk(6'b010000, 8'b000_000_00);
    tbl[2]  = mk(6'b001000, 8'b000_000_00);
    tbl[3]  = mk(6'b001000, 8'b100_000_10);
    tbl[4]  = mk(6'b001000, 8'b000_000_10);
    tbl[5]  = mk(6'b000001, 8'b000_100_10);
    tbl[6]  = mk(6'b000101, 8'b000_000_10);
    tbl[7]  = mk(6'b000100, 8'b000_000_00);
    tbl[8]  = mk(6'b000100, 8'b010_000_10);
    tbl[9]  = mk(6'b000000, 8'b000_000_10);
    tbl[10] = mk(6'b010001, 8'b000_000_00);
    tbl[11] = mk(6'b000010, 8'b000_000_00);
    tbl[12] = mk(6'b000010, 8'b011_000_10);
    tbl[13] = mk(6'b000011, 8'b000_001_10);
    tbl[14] = mk(6'b000110, 8'b000_000_10);
    tbl[15] = mk(6'b000110, 8'b000_000_00);
    tbl[16] = mk(6'b000110, 8'b010_000_10);
    tbl[17] = mk(6'b100111, 8'b000_000_00);
    tbl[18] = mk(6'b000001, 8'b000_000_00);
    tbl[19] = mk(6'b000001, 8'b000_000_00);
    tbl[20] = mk(6'b000110, 8'b011_000_10);
    tbl[21] = mk(6'b100001, 8'b000_000_00);
    tbl[22] = mk(6'b000000, 8'b000_000_00);
    for (int i = 0; i < 23; i++) begin
      {rst, disconnected_s, lt_req, at_cmd_req, at_rsp_req, trans_sent} = tbl[i].in;
      tick();
      check($sformatf("vec%0d", i), 32'(w_out), 32'(tbl[i].exp));
    end
    // LT issue, completion 30 cycles later, then two gap cycles
    do_reset();
    lt_req = 1'b1;
    wait_sel(10, c, cy);
    check("lt_issue", 32'(c), 32'd4);
    lt_req = 1'b0;
    repeat (29) tick();
    trans_sent = 1'b1;
    tick();
    trans_sent = 1'b0;
    check("lt_ack", 32'({lt_ack, busy}), 32'b11);
    tick();
    check("gap2_busy", 32'({lt_ack, busy}), 32'b01);
    tick();
    check("gap_done", 32'(busy), 32'd0);
    // timeout after 255 WAIT cycles, then re-issue after the gap
    at_cmd_req = 1'b1;
    wait_sel(10, c, cy);
    check("cmd_issue", 32'(c), 32'd2);
    t = 0;
    saw = 1'b0;
    while (!timeout_err && t < 400) begin
      tick();
      t++;
      if (at_cmd_ack) saw = 1'b1;
    end
    check("timeout_latency", 32'(t), 32'd255);
    check("timeout_no_ack", 32'(saw), 32'd0);
    tick();
    check("timeout_pulse", 32'(timeout_err), 32'd0);
    wait_sel(10, c, cy);
    check("reissue_code", 32'(c), 32'd2);
    check("reissue_delay", 32'(cy), 32'd2);
    // completion on the final WAIT cycle beats the timeout
    saw = 1'b0;
    repeat (254) begin
      tick();
      if (timeout_err) saw = 1'b1;
    end
    trans_sent = 1'b1;
    tick();
    trans_sent = 1'b0;
    check("last_cycle_ack", 32'({at_cmd_ack, timeout_err}), 32'b10);
    check("no_early_timeout", 32'(saw), 32'd0);
    at_cmd_req = 1'b0;
    tick();
    check("no_late_timeout", 32'(timeout_err), 32'd0);
    // arbitration order with all requests held from reset
    do_reset();
    {lt_req, at_cmd_req, at_rsp_req} = 3'b111;
    order[0] = 3'd4;
    order[1] = 3'd3;
    order[2] = 3'd2;
    for (int k = 0; k < 4; k++) begin
      wait_sel(20, c, cy);
      check($sformatf("grant%0d", k), 32'(c), 32'(k < 3 ? order[k] : 3'd4));
      trans_sent = 1'b1;
      tick();
      trans_sent = 1'b0;
      check($sformatf("grant%0d_ack", k), 32'({lt_ack, at_cmd_ack, at_rsp_ack}),
            32'(c == 3'd4 ? 3'b100 : c == 3'd2 ? 3'b010 : 3'b001));
      if (c == 3'd4) lt_req = 1'b0;
      if (c == 3'd2) at_cmd_req = 1'b0;
      if (c == 3'd3) at_rsp_req = 1'b0;
      if (k == 2) lt_req = 1'b1;
    end
    lt_req = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
